// File: rtl/mux_arb_pkg.sv
// Shared encodings and the round-robin pick for the 2:1 line-mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_TURN   = 2'd3
  } arb_state_e;

  // Mux control encodings: i_en high tristates the line, i_sel high picks i_data_0.
  localparam logic MUX_HIZ = 1'b1;
  localparam logic SEL_D0  = 1'b1;
  localparam logic SEL_D1  = 1'b0;

  // Round-robin pick; on a tie the side that did not own the line last wins.
  function automatic arb_state_e arb_pick(input logic req0, input logic req1,
                                          input logic last_owner);
    arb_state_e pick;
    if (req0 && req1) begin
      pick = last_owner ? ST_GRANT0 : ST_GRANT1;
    end else if (req0) begin
      pick = ST_GRANT0;
    end else if (req1) begin
      pick = ST_GRANT1;
    end else begin
      pick = ST_IDLE;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_arb_hold_cnt.sv
// Loadable, clearable, saturating counter used for both grant hold time and turnaround.
module mux_arb_hold_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_sat_val,
  output logic [CNT_W-1:0] o_cnt
);

  // Clear beats load beats increment; increment stops at the saturation value.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      o_cnt <= '0;
    end else if (i_load) begin
      o_cnt <= i_load_val;
    end else if (i_inc && (o_cnt < i_sat_val)) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux_2_to_1_arbiter.sv
// Round-robin arbiter owning the enable/select of a shared 2:1 tristate line mux.
// Ownership is bounded while the other side waits, and every hand-over passes
// through at least TURN_CYCLES high-Z cycles.
module mux_2_to_1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_mux_en,
  output logic             o_mux_sel,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_hold_cnt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             last_owner_q;
  logic             last_owner_d;
  logic             cnt_load;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_sat;
  logic             gnt0_d;
  logic             gnt1_d;
  logic             mux_en_d;
  logic             mux_sel_d;
  logic             busy_d;

  // Hold/turn counter restarts at zero on every state change.
  mux_arb_hold_cnt #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .i_clk      (i_clk),
    .i_clr      (i_rst),
    .i_load     (cnt_load),
    .i_load_val ('0),
    .i_inc      (cnt_inc),
    .i_sat_val  (cnt_sat),
    .o_cnt      (o_hold_cnt)
  );

  // Next state, round-robin pointer and next-cycle output values.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_inc      = 1'b0;
    cnt_sat      = '0;

    case (state_q)
      ST_IDLE: begin
        state_d = arb_pick(i_req0, i_req1, last_owner_q);
      end
      ST_GRANT0: begin
        cnt_inc = 1'b1;
        cnt_sat = HOLD_LAST;
        if (!i_req0 || ((o_hold_cnt == HOLD_LAST) && i_req1)) begin
          state_d      = ST_TURN;
          last_owner_d = 1'b0;
        end
      end
      ST_GRANT1: begin
        cnt_inc = 1'b1;
        cnt_sat = HOLD_LAST;
        if (!i_req1 || ((o_hold_cnt == HOLD_LAST) && i_req0)) begin
          state_d      = ST_TURN;
          last_owner_d = 1'b1;
        end
      end
      ST_TURN: begin
        cnt_inc = 1'b1;
        cnt_sat = TURN_LAST;
        if (o_hold_cnt >= TURN_LAST) begin
          state_d = arb_pick(i_req0, i_req1, last_owner_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cnt_load  = (state_d != state_q);
    gnt0_d    = (state_d == ST_GRANT0);
    gnt1_d    = (state_d == ST_GRANT1);
    mux_en_d  = ~(gnt0_d | gnt1_d);
    busy_d    = (state_d != ST_IDLE);
    mux_sel_d = o_mux_sel;
    if (gnt0_d) begin
      mux_sel_d = SEL_D0;
    end else if (gnt1_d) begin
      mux_sel_d = SEL_D1;
    end
  end

  // State, pointer and registered outputs; reset drops any grant immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      o_gnt0       <= 1'b0;
      o_gnt1       <= 1'b0;
      o_mux_en     <= MUX_HIZ;
      o_mux_sel    <= SEL_D1;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      o_gnt0       <= gnt0_d;
      o_gnt1       <= gnt1_d;
      o_mux_en     <= mux_en_d;
      o_mux_sel    <= mux_sel_d;
      o_busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
// Directed bench for the 2:1 line-mux arbiter (MAX_HOLD=4, TURN_CYCLES=1),
// with a behavioural tristate line mux on the arbiter outputs.
module tb_mux_2_to_1_arbiter;

  localparam int unsigned MAX_HOLD    = 4;
  localparam int unsigned TURN_CYCLES = 1;
  localparam int unsigned CNT_W       = 4;

  logic             clk;
  logic             rst;
  logic             req0;
  logic             req1;
  logic             gnt0;
  logic             gnt1;
  logic             mux_en;
  logic             mux_sel;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;
  logic [7:0]       data_0;
  logic [7:0]       data_1;
  logic [7:0]       mux_z;

  int tests;
  int fails;

  mux_2_to_1_arbiter #(
    .MAX_HOLD    (MAX_HOLD),
    .TURN_CYCLES (TURN_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req0     (req0),
    .i_req1     (req1),
    .o_gnt0     (gnt0),
    .o_gnt1     (gnt1),
    .o_mux_en   (mux_en),
    .o_mux_sel  (mux_sel),
    .o_busy     (busy),
    .o_hold_cnt (hold_cnt)
  );

  // Behavioural stand-in for the shared tristate line mux.
  assign mux_z = mux_en ? 8'hzz : (mux_sel ? data_0 : data_1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle and land on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full output check against a hand-derived expected grant/hold/busy.
  task automatic chk_state(input string tag, input logic e_g0, input logic e_g1,
                           input int e_hold, input logic e_busy);
    logic [7:0] e_z;
    e_z = e_g0 ? data_0 : (e_g1 ? data_1 : 8'hzz);
    chk({tag, ".gnt"},  {6'd0, gnt0, gnt1}, {6'd0, e_g0, e_g1});
    chk({tag, ".en"},   {7'd0, mux_en},     {7'd0, ~(e_g0 | e_g1)});
    chk({tag, ".busy"}, {7'd0, busy},       {7'd0, e_busy});
    chk({tag, ".hold"}, 8'(hold_cnt),       8'(e_hold));
    chk({tag, ".z"},    mux_z,              e_z);
  endtask

  initial begin
    logic       first;
    logic       e_g0;
    logic       e_g1;
    int         pos;
    int         e_hold;
    logic       p_g0;
    logic       p_g1;
    logic [CNT_W-1:0] p_hold;
    logic       p_z;
    int         last_seen;

    tests  = 0;
    fails  = 0;
    data_0 = 8'hA5;
    data_1 = 8'h3C;
    rst    = 1'b1;
    req0   = 1'b0;
    req1   = 1'b0;

    // 1) reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk_state("rst", 1'b0, 1'b0, 0, 1'b0);
    chk("rst.sel", {7'd0, mux_sel}, 8'd0);
    rst = 1'b0;
    step();
    chk_state("idle0", 1'b0, 1'b0, 0, 1'b0);

    // 2) req0 alone for 6 sampling edges
    req0 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_state($sformatf("solo0[%0d]", k), 1'b1, 1'b0, (k < 3) ? k : 3, 1'b1);
      chk($sformatf("solo0[%0d].sel", k), {7'd0, mux_sel}, 8'd1);
    end
    req0 = 1'b0;
    step();
    chk_state("solo0.turn", 1'b0, 1'b0, 0, 1'b1);
    chk("solo0.turn.sel", {7'd0, mux_sel}, 8'd1);
    step();
    chk_state("solo0.idle", 1'b0, 1'b0, 0, 1'b0);

    // 3) continuous contention; last owner was 0, so requester 1 goes first
    req0  = 1'b1;
    req1  = 1'b1;
    first = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      pos = i % 10;
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      e_hold = 0;
      if (pos < 4) begin
        e_g1 = first;
        e_g0 = ~first;
        e_hold = pos;
      end else if (pos >= 5 && pos < 9) begin
        e_g0 = first;
        e_g1 = ~first;
        e_hold = pos - 5;
      end
      chk_state($sformatf("rr[%0d]", i), e_g0, e_g1, e_hold, 1'b1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk_state("rr.idle", 1'b0, 1'b0, 0, 1'b0);

    // 4) req1 for two cycles, then a tie during turnaround goes to requester 0
    req1 = 1'b1;
    step();
    chk_state("g1[0]", 1'b0, 1'b1, 0, 1'b1);
    chk("g1[0].sel", {7'd0, mux_sel}, 8'd0);
    step();
    chk_state("g1[1]", 1'b0, 1'b1, 1, 1'b1);
    req1 = 1'b0;
    step();
    chk_state("g1.turn", 1'b0, 1'b0, 0, 1'b1);
    chk("g1.turn.sel", {7'd0, mux_sel}, 8'd0);
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    chk_state("tie.g0", 1'b1, 1'b0, 0, 1'b1);
    chk("tie.g0.sel", {7'd0, mux_sel}, 8'd1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    chk_state("tie.turn", 1'b0, 1'b0, 0, 1'b1);
    step();
    chk_state("tie.idle", 1'b0, 1'b0, 0, 1'b0);

    // 5) reset in the second cycle of a req1 hold
    req1 = 1'b1;
    step();
    chk_state("pre_rst[0]", 1'b0, 1'b1, 0, 1'b1);
    step();
    chk_state("pre_rst[1]", 1'b0, 1'b1, 1, 1'b1);
    rst = 1'b1;
    step();
    chk_state("mid_rst", 1'b0, 1'b0, 0, 1'b0);
    chk("mid_rst.sel", {7'd0, mux_sel}, 8'd0);
    rst  = 1'b0;
    req0 = 1'b1;
    step();
    chk_state("post_rst.tie", 1'b1, 1'b0, 0, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    chk_state("post_rst.idle", 1'b0, 1'b0, 0, 1'b0);

    // 6) random request toggling with invariant checks
    p_g0      = 1'b0;
    p_g1      = 1'b0;
    p_hold    = '0;
    p_z       = 1'b1;
    last_seen = -1;
    for (int c = 0; c < 2000; c++) begin
      step();
      chk("rnd.mutex", {7'd0, gnt0 & gnt1}, 8'd0);
      chk("rnd.en", {7'd0, mux_en}, {7'd0, ~(gnt0 | gnt1)});
      chk("rnd.hold_max", {7'd0, hold_cnt <= CNT_W'(MAX_HOLD - 1)}, 8'd1);
      if (p_g0 && (p_hold == CNT_W'(MAX_HOLD - 1)) && req1)
        chk("rnd.preempt0", {7'd0, gnt0}, 8'd0);
      if (p_g1 && (p_hold == CNT_W'(MAX_HOLD - 1)) && req0)
        chk("rnd.preempt1", {7'd0, gnt1}, 8'd0);
      if ((gnt0 || gnt1) && (last_seen >= 0) && (last_seen != (gnt1 ? 1 : 0)))
        chk("rnd.zgap", {7'd0, p_z}, 8'd1);
      if (gnt0) last_seen = 0;
      if (gnt1) last_seen = 1;
      p_g0   = gnt0;
      p_g1   = gnt1;
      p_hold = hold_cnt;
      p_z    = mux_en;
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
